// File: rtl/oled_frame_streamer_pkg.sv
// Shared types and command tables for the OLED frame streamer: FSM state
// encoding, panel geometry and the init / address-window command sequences.
package oled_pkg;

  typedef enum logic [2:0] {
    PWR,
    INIT,
    IDLE,
    ADDR,
    FETCH,
    LOAD,
    SEND
  } state_t;

  localparam int OLED_COLS  = 128;
  localparam int OLED_PAGES = 8;
  localparam int INIT_LEN   = 25;
  localparam int ADDR_LEN   = 6;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  // Full-screen column window (0..127) then page window (0..7).
  localparam logic [7:0] ADDR_ROM [ADDR_LEN] = '{
    8'h21, 8'h00, 8'(OLED_COLS - 1), 8'h22, 8'h00, 8'(OLED_PAGES - 1)
  };

endpackage

// File: rtl/oled_frame_streamer_if.sv
// Byte handshake between the frame streamer (master) and the SPI serializer
// (slave): one byte plus its data/command flag per valid/ready transfer.
interface oled_frame_streamer_if;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_dc, output tx_valid, input tx_ready);
  modport slave  (input tx_byte, input tx_dc, input tx_valid, output tx_ready);
endinterface

// File: rtl/oled_cmd_rom.sv
// Combinational index-to-byte lookup for the panel init sequence and the
// address-window preamble; out-of-range indices read as 0.
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic       addr_sel_i,
  input  logic [4:0] idx_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    if (addr_sel_i) begin
      if (int'(idx_i) < ADDR_LEN) byte_o = ADDR_ROM[idx_i[2:0]];
    end else begin
      if (int'(idx_i) < INIT_LEN) byte_o = INIT_ROM[idx_i];
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// OLED frame streamer: power-up wait, controller init, then per-request
// address preamble plus page-major pixel bytes over a valid/ready handshake.
// Optional OLED_INVERT_EN adds an 'invert' input that XORs pixel bytes with FF.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int NUM_COLS  = OLED_COLS,
  parameter int NUM_PAGES = OLED_PAGES,
  parameter int PWR_WAIT  = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_req,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         pix_rd,
  output logic [$clog2(NUM_PAGES)-1:0] pix_page,
  output logic [$clog2(NUM_COLS)-1:0]  pix_col,
  input  logic [7:0]                   pix_data,
`ifdef OLED_INVERT_EN
  input  logic                         invert,
`endif
  oled_frame_streamer_if.master        tx
);

  localparam int CW  = $clog2(NUM_COLS);
  localparam int PGW = $clog2(NUM_PAGES);
  localparam int PCW = $clog2(PWR_WAIT + 1);

  state_t         state_q, state_d;
  logic [PCW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [4:0]     idx_q, idx_d;
  logic [PGW-1:0] page_q, page_d;
  logic [CW-1:0]  col_q, col_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_dc_q, tx_dc_d;
  logic           tx_valid_q, tx_valid_d;
  logic           pending_q, pending_d;
  logic [7:0]     pix_mask;
  logic [7:0]     rom_byte;
  logic [4:0]     last_idx;
  logic           xfer;

`ifdef OLED_INVERT_EN
  logic invert_q, invert_d;
  assign pix_mask = {8{invert_q}};
`else
  assign pix_mask = 8'h00;
`endif

  oled_cmd_rom u_cmd_rom (
    .addr_sel_i (state_q == ADDR),
    .idx_i      (idx_q),
    .byte_o     (rom_byte)
  );

  assign xfer     = tx_valid_q && tx.tx_ready;
  assign last_idx = (state_q == ADDR) ? 5'(ADDR_LEN - 1) : 5'(INIT_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR;
      pwr_cnt_q  <= '0;
      idx_q      <= '0;
      page_q     <= '0;
      col_q      <= '0;
      tx_byte_q  <= 8'h00;
      tx_dc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      pending_q  <= 1'b0;
`ifdef OLED_INVERT_EN
      invert_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      col_q      <= col_d;
      tx_byte_q  <= tx_byte_d;
      tx_dc_q    <= tx_dc_d;
      tx_valid_q <= tx_valid_d;
      pending_q  <= pending_d;
`ifdef OLED_INVERT_EN
      invert_q   <= invert_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    idx_d      = idx_q;
    page_d     = page_q;
    col_d      = col_q;
    tx_byte_d  = tx_byte_q;
    tx_dc_d    = tx_dc_q;
    tx_valid_d = tx_valid_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
`ifdef OLED_INVERT_EN
    invert_d   = invert_q;
`endif

    // One-deep request memory; IDLE consumes requests directly instead.
    if (frame_req && state_q != IDLE) pending_d = 1'b1;

    unique case (state_q)
      PWR: begin
        if (pwr_cnt_q == PCW'(PWR_WAIT - 1)) begin
          state_d = INIT;
          idx_d   = '0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end

      // Command bytes: load when the output register is empty, advance on transfer.
      INIT, ADDR: begin
        if (!tx_valid_q) begin
          tx_byte_d  = rom_byte;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else if (xfer) begin
          tx_valid_d = 1'b0;
          if (idx_q == last_idx) begin
            state_d = (state_q == INIT) ? IDLE : FETCH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      IDLE: begin
        if (frame_req || pending_q) begin
          state_d   = ADDR;
          idx_d     = '0;
          page_d    = '0;
          col_d     = '0;
          pending_d = 1'b0;
`ifdef OLED_INVERT_EN
          invert_d  = invert;
`endif
        end
      end

      FETCH: state_d = LOAD;

      LOAD: begin
        tx_byte_d  = pix_data ^ pix_mask;
        tx_dc_d    = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (col_q == CW'(NUM_COLS - 1)) begin
            col_d = '0;
            if (page_q == PGW'(NUM_PAGES - 1)) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              page_d  = page_q + 1'b1;
              state_d = FETCH;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = FETCH;
          end
        end
      end

      default: state_d = PWR;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign pix_rd      = (state_q == FETCH);
  assign pix_page    = page_q;
  assign pix_col     = col_q;
  assign tx.tx_byte  = tx_byte_q;
  assign tx.tx_dc    = tx_dc_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer: randomized ready/pixel stimulus
// compared against a byte-stream reference built from the panel protocol.
module tb_oled_frame_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_req = 1'b0;
  logic       busy, frame_done, pix_rd;
  logic [2:0] pix_page;
  logic [6:0] pix_col;
  logic [7:0] pix_data;
`ifdef OLED_INVERT_EN
  logic       invert = 1'b0;
`endif

  oled_frame_streamer_if txi ();

  oled_frame_streamer #(.NUM_COLS(128), .NUM_PAGES(8), .PWR_WAIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_rd     (pix_rd),
    .pix_page   (pix_page),
    .pix_col    (pix_col),
    .pix_data   (pix_data),
`ifdef OLED_INVERT_EN
    .invert     (invert),
`endif
    .tx         (txi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] init_seq [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  logic [7:0] addr_seq [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  // Renderer model: image memory, answered one cycle after each fetch strobe.
  logic [7:0] img [8][128];
  always @(posedge clk) pix_data <= pix_rd ? img[pix_page][pix_col] : 8'($urandom);

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  int req_plan[$];
  bit req_on_done = 1'b0;
  int inv_toggle  = -1;
  int done_cnt, done_idx, stall_bad, stall_seen, rd_bad, data_starts, first_valid;
  bit timed_out;

  initial begin
    txi.tx_ready = 1'b0;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_img(input int kind);
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        case (kind)
          0:       img[p][c] = {p[2:0], c[4:0]};
          1:       img[p][c] = 8'($urandom);
          default: img[p][c] = 8'h0F;
        endcase
  endtask

  task automatic push_init();
    foreach (init_seq[i]) exp_q.push_back({1'b0, init_seq[i]});
  endtask

  task automatic push_frame(input logic [7:0] mask);
    foreach (addr_seq[i]) exp_q.push_back({1'b0, addr_seq[i]});
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        exp_q.push_back({1'b1, img[p][c] ^ mask});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_req = 1'b0;
    txi.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Drives tx_ready / frame_req each cycle and records every accepted byte.
  task automatic collect(input int n, input int budget, input int rpct);
    bit prev_stall = 0, prev_v = 0, rd1 = 0, rd2 = 0;
    logic [8:0] prev_b = '0, cur;
    cap.delete();
    done_cnt = 0; done_idx = -1; stall_bad = 0; stall_seen = 0;
    rd_bad = 0; data_starts = 0; first_valid = -1; timed_out = 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      txi.tx_ready = ($urandom_range(99) < rpct);
      frame_req = 1'b0;
      foreach (req_plan[i]) if (req_plan[i] == cyc) frame_req = 1'b1;
`ifdef OLED_INVERT_EN
      if (cyc == inv_toggle) invert = ~invert;
`endif
      #1;
      cur = {txi.tx_dc, txi.tx_byte};
      if (prev_stall) begin
        stall_seen++;
        if (!txi.tx_valid || cur !== prev_b) stall_bad++;
      end
      if (txi.tx_valid && !prev_v && txi.tx_dc) begin
        data_starts++;
        if (!(rd2 && !rd1)) rd_bad++;
      end
      if (txi.tx_valid && first_valid < 0) first_valid = cyc;
      if (frame_done) begin
        done_cnt++;
        done_idx = cap.size();
        if (req_on_done) begin
          frame_req = 1'b1;
          req_on_done = 1'b0;
        end
      end
      prev_stall = txi.tx_valid && !txi.tx_ready;
      prev_b = cur;
      prev_v = txi.tx_valid;
      rd2 = rd1;
      rd1 = pix_rd;
      if (txi.tx_valid && txi.tx_ready) begin
        cap.push_back(cur);
        if (cap.size() == n) begin
          timed_out = 0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 8;
    if (txi.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b exp 0", txi.tx_valid); end
    if (txi.tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte got %h exp 00", txi.tx_byte); end
    if (txi.tx_dc !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_dc got %b exp 0", txi.tx_dc); end
    if (pix_rd !== 1'b0)       begin n_fail++; $display("FAIL reset_pix_rd got %b exp 0", pix_rd); end
    if (pix_page !== 3'd0)     begin n_fail++; $display("FAIL reset_pix_page got %0d exp 0", pix_page); end
    if (pix_col !== 7'd0)      begin n_fail++; $display("FAIL reset_pix_col got %0d exp 0", pix_col); end
    if (busy !== 1'b1)         begin n_fail++; $display("FAIL reset_busy got %b exp 1", busy); end
    if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_init();
    req_plan = {};
    exp_q.delete();
    push_init();
    collect(25, 300, 100);
    n_checks += 2;
    if (timed_out) begin n_fail++; $display("FAIL init_timeout got %0d bytes exp 25", cap.size()); end
    if (first_valid !== 16) begin n_fail++; $display("FAIL init_latency got %0d exp 16", first_valid); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL init_byte[%0d] got %h exp %h", i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_after got %b exp 0", busy); end
    $display("test_init: %0d bytes captured", cap.size());
  endtask

  task automatic test_frame(input int kind, input int rpct, input string tag);
    fill_img(kind);
    exp_q.delete();
    push_frame(8'h00);
    req_plan = {0};
    collect(1030, 15000, rpct);
    n_checks += 5;
    if (timed_out) begin n_fail++; $display("FAIL %s_timeout got %0d bytes exp 1030", tag, cap.size()); end
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_count got %0d exp 1", tag, done_cnt); end
    if (done_idx !== 1029) begin n_fail++; $display("FAIL %s_done_index got %0d exp 1029", tag, done_idx); end
    if (rd_bad !== 0) begin n_fail++; $display("FAIL %s_pix_rd_lead got %0d bad exp 0", tag, rd_bad); end
    if (data_starts !== 1024) begin n_fail++; $display("FAIL %s_data_starts got %0d exp 1024", tag, data_starts); end
    if (rpct < 100) begin
      n_checks += 2;
      if (stall_bad !== 0) begin n_fail++; $display("FAIL %s_stall_stable got %0d changes exp 0", tag, stall_bad); end
      if (stall_seen == 0) begin n_fail++; $display("FAIL %s_stall_seen got 0 exp >0", tag); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte[%0d] got %h exp %h", tag, i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || txi.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle_after got busy=%b valid=%b exp 0 0", tag, busy, txi.tx_valid);
    end
    $display("test_%s: %0d bytes, %0d stalls", tag, cap.size(), stall_seen);
  endtask

  task automatic idle_window(input string tag);
    int bad = 0;
    frame_req = 1'b0;
    txi.tx_ready = 1'b1;
    repeat (100) begin
      @(negedge clk); #1;
      if (txi.tx_valid || busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_no_extra_frame got %0d active cycles exp 0", tag, bad); end
  endtask

  task automatic test_back_to_back();
    fill_img(1);
    exp_q.delete();
    push_frame(8'h00);
    push_frame(8'h00);
    req_plan = {0};
    req_on_done = 1'b1;
    collect(2060, 15000, 100);
    n_checks += 2;
    if (timed_out) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes exp 2060", cap.size()); end
    if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_byte[%0d] got %h exp %h", i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    idle_window("b2b");
    $display("test_back_to_back: %0d bytes, %0d frames", cap.size(), done_cnt);
  endtask

  task automatic test_pending();
    fill_img(1);
    apply_reset();
    rst = 1'b0;
    exp_q.delete();
    push_init();
    push_frame(8'h00);
    push_frame(8'h00);
    req_plan = {20, 500, 1500, 2500};
    collect(2085, 15000, 100);
    n_checks += 2;
    if (timed_out) begin n_fail++; $display("FAIL pending_timeout got %0d bytes exp 2085", cap.size()); end
    if (done_cnt !== 2) begin n_fail++; $display("FAIL pending_done_count got %0d exp 2", done_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pending_byte[%0d] got %h exp %h", i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    idle_window("pending");
    $display("test_pending: %0d bytes, %0d frames", cap.size(), done_cnt);
  endtask

  task automatic test_reset_mid();
    fill_img(0);
    req_plan = {0, 100};
    collect(507, 5000, 100);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL rstmid_timeout got %0d bytes exp 507", cap.size()); end
    rst = 1'b1;
    frame_req = 1'b0;
    @(negedge clk); #1;
    n_checks += 4;
    if (txi.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_valid got %b exp 0", txi.tx_valid); end
    if (txi.tx_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_byte got %h exp 00", txi.tx_byte); end
    if (busy !== 1'b1)         begin n_fail++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    if (pix_col !== 7'd0)      begin n_fail++; $display("FAIL rstmid_pix_col got %0d exp 0", pix_col); end
    rst = 1'b0;
    req_plan = {};
    exp_q.delete();
    push_init();
    collect(25, 300, 100);
    n_checks += 2;
    if (timed_out) begin n_fail++; $display("FAIL rstmid_init_timeout got %0d bytes exp 25", cap.size()); end
    if (first_valid !== 16) begin n_fail++; $display("FAIL rstmid_init_latency got %0d exp 16", first_valid); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_init_byte[%0d] got %h exp %h", i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    idle_window("rstmid_pending_cleared");
    $display("test_reset_mid: init resent, %0d bytes", cap.size());
  endtask

`ifdef OLED_INVERT_EN
  task automatic test_invert();
    fill_img(2);
    invert = 1'b1;
    exp_q.delete();
    push_frame(8'hFF);
    push_frame(8'h00);
    req_plan = {0, 800};
    inv_toggle = 1500;
    collect(2060, 15000, 100);
    inv_toggle = -1;
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL invert_timeout got %0d bytes exp 2060", cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL invert_byte[%0d] got %h exp %h", i, (i < cap.size()) ? cap[i] : 9'h1FF, exp_q[i]);
      end
    end
    idle_window("invert");
    $display("test_invert: %0d bytes", cap.size());
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_frame(0, 100, "frame");
    test_frame(1, 30, "backpressure");
    test_back_to_back();
    test_pending();
    test_reset_mid();
`ifdef OLED_INVERT_EN
    test_invert();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
